// File: rtl/scan_mux.sv
// Registered N-to-1 channel mux with manual select, round-robin scan and hold.
// Outputs are fully registered; sel_change strobes on every channel switch.
module scan_mux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int DWELL    = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_change
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [SEL_W-1:0]  next_sel;
    logic [WIDTH-1:0]  data_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        next_sel = cur_sel;
        data_d   = data_out;

        if (hold) begin
            state_d = FROZEN;
        end else if (mode) begin
            state_d = SCAN;
        end else begin
            state_d = MANUAL;
        end

        unique case (state_d)
            MANUAL: begin
                cnt_d = '0;
                if (int'(sel) < CHANNELS) begin
                    next_sel = sel;
                end
            end
            SCAN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    next_sel = (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FROZEN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = MANUAL;
                cnt_d   = '0;
            end
        endcase

        // Frozen output holds its last value rather than tracking data_in
        if (state_d != FROZEN) begin
            data_d = data_in[int'(next_sel)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MANUAL;
            cnt_q      <= '0;
            cur_sel    <= '0;
            data_out   <= '0;
            sel_change <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel    <= next_sel;
            data_out   <= data_d;
            sel_change <= (next_sel != cur_sel);
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4x1 manual instance and a 3x4 scan instance.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4 channels, 1 bit, dwell 4
    logic        rst4;
    logic [3:0]  din4;
    logic [1:0]  sel4;
    logic        mode4;
    logic        hold4;
    logic [0:0]  dout4;
    logic [1:0]  cur4;
    logic        chg4;

    // 3 channels, 4 bits, dwell 2
    logic        rst3;
    logic [11:0] din3;
    logic [1:0]  sel3;
    logic        mode3;
    logic        hold3;
    logic [3:0]  dout3;
    logic [1:0]  cur3;
    logic        chg3;

    scan_mux #(.CHANNELS(4), .WIDTH(1), .DWELL(4)) u4 (
        .clk        (clk),
        .rst        (rst4),
        .data_in    (din4),
        .sel        (sel4),
        .mode       (mode4),
        .hold       (hold4),
        .data_out   (dout4),
        .cur_sel    (cur4),
        .sel_change (chg4)
    );

    scan_mux #(.CHANNELS(3), .WIDTH(4), .DWELL(2)) u3 (
        .clk        (clk),
        .rst        (rst3),
        .data_in    (din3),
        .sel        (sel3),
        .mode       (mode3),
        .hold       (hold3),
        .data_out   (dout3),
        .cur_sel    (cur3),
        .sel_change (chg3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the 3-channel instance against (cur_sel, data_out, sel_change)
    task automatic chk3(input string tag, input logic [1:0] c,
                        input logic [3:0] d, input logic s);
        chk({tag, ".cur"}, 32'(cur3), 32'(c));
        chk({tag, ".dat"}, 32'(dout3), 32'(d));
        chk({tag, ".chg"}, 32'(chg3), 32'(s));
    endtask

    logic [1:0] scan_c [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [3:0] scan_d [7] = '{4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'hA, 4'hA};
    logic       scan_s [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst4 = 1'b1; din4 = '0; sel4 = '0; mode4 = 1'b0; hold4 = 1'b0;
        rst3 = 1'b1; din3 = '0; sel3 = '0; mode3 = 1'b0; hold3 = 1'b0;
        #1;

        // Reset, then manual select on the 4x1 instance
        tick();
        tick();
        chk("rst4.dat", 32'(dout4), 32'd0);
        chk("rst4.cur", 32'(cur4), 32'd0);
        chk("rst4.chg", 32'(chg4), 32'd0);
        chk3("rst3", 2'd0, 4'h0, 1'b0);

        rst4 = 1'b0; din4 = 4'b0100; sel4 = 2'd2;
        tick();
        chk("man.dat", 32'(dout4), 32'd1);
        chk("man.cur", 32'(cur4), 32'd2);
        chk("man.chg", 32'(chg4), 32'd1);
        tick();
        chk("man.chg2", 32'(chg4), 32'd0);
        chk("man.dat2", 32'(dout4), 32'd1);
        sel4 = 2'd3;
        tick();
        chk("man3.dat", 32'(dout4), 32'd0);
        chk("man3.cur", 32'(cur4), 32'd3);
        chk("man3.chg", 32'(chg4), 32'd1);

        // Sweep every select against every one-hot input
        for (int s = 0; s < 4; s++) begin
            for (int h = 0; h < 4; h++) begin
                sel4 = 2'(s);
                din4 = 4'b0001 << h;
                tick();
                chk($sformatf("sweep.s%0d.h%0d", s, h),
                    32'(dout4), (s == h) ? 32'd1 : 32'd0);
            end
        end

        // Round-robin wrap on the 3x4 instance, dwell 2
        rst3 = 1'b0; din3 = 12'hCBA; sel3 = 2'd0;
        tick();
        chk3("pre", 2'd0, 4'hA, 1'b0);
        mode3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk3($sformatf("scan%0d", i), scan_c[i], scan_d[i], scan_s[i]);
        end

        // Advance to channel 1 with counter at 1, then hold for 5 edges
        tick();
        chk3("to1", 2'd1, 4'hB, 1'b1);
        tick();
        chk3("mid1", 2'd1, 4'hB, 1'b0);
        hold3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din3 = 12'h123 + 12'(i * 12'h111);
            tick();
            chk3($sformatf("hold%0d", i), 2'd1, 4'hB, 1'b0);
        end
        hold3 = 1'b0; din3 = 12'h987;
        tick();
        chk3("resume", 2'd2, 4'h9, 1'b1);
        tick();
        chk3("cnt1", 2'd2, 4'h9, 1'b0);

        // Reset while frozen mid-scan, then confirm dwell restarts at 0
        hold3 = 1'b1; rst3 = 1'b1;
        tick();
        chk3("midrst", 2'd0, 4'h0, 1'b0);
        rst3 = 1'b0; hold3 = 1'b0; din3 = 12'hCBA;
        tick();
        chk3("re0", 2'd0, 4'hA, 1'b0);
        tick();
        chk3("re1", 2'd1, 4'hB, 1'b1);

        // Out-of-range manual select is ignored
        mode3 = 1'b0; sel3 = 2'd1;
        tick();
        chk3("oor.pre", 2'd1, 4'hB, 1'b0);
        sel3 = 2'd3;
        tick();
        chk3("oor0", 2'd1, 4'hB, 1'b0);
        din3 = 12'h5E7;
        tick();
        chk3("oor1", 2'd1, 4'hE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
